// File: rtl/vga_timing_decoder_pkg.sv
// Shared 640x480 timing defaults and lock-state type for the VGA timing decoder.
// Coordinate counters are 10 bits wide and saturate at all-ones.
package VGA_timing_pkg;

    localparam int VGA_H_SYNC_CYC = 96;
    localparam int VGA_H_BACK     = 48;
    localparam int VGA_H_ACT      = 640;
    localparam int VGA_H_TOTAL    = 800;
    localparam int VGA_V_SYNC_CYC = 2;
    localparam int VGA_V_BACK     = 33;
    localparam int VGA_V_ACT      = 480;
    localparam int VGA_V_TOTAL    = 525;

    localparam int                CNT_W   = 10;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } lock_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_timing_decoder_sync_edge_detect.sv
// Enable-gated edge detector for one sync line; the previous-value register
// resets low so a sync held low out of reset never reports a falling edge.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic sync_i,
    output logic fall_o,
    output logic rise_o
);

    logic prev_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else if (en_i) begin
            prev_q <= sync_i;
        end
    end

    assign fall_o = en_i &  prev_q & ~sync_i;
    assign rise_o = en_i & ~prev_q &  sync_i;

endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers pixel coordinates from sampled VGA syncs, verifies line/frame geometry,
// and emits registered, lock-qualified pixels for a downstream compare stage.
module vga_timing_decoder
    import VGA_timing_pkg::*;
#(
    parameter int H_SYNC_CYC = VGA_H_SYNC_CYC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int H_ACT      = VGA_H_ACT,
    parameter int H_TOTAL    = VGA_H_TOTAL,
    parameter int V_SYNC_CYC = VGA_V_SYNC_CYC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter int V_ACT      = VGA_V_ACT,
    parameter int V_TOTAL    = VGA_V_TOTAL
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Enable,
    input  logic             iClear_err,
    input  logic             iVGA_H_SYNC,
    input  logic             iVGA_V_SYNC,
    input  logic [7:0]       iVGA_R,
    input  logic [7:0]       iVGA_G,
    input  logic [7:0]       iVGA_B,
    output logic             oPixel_valid,
    output logic [CNT_W-1:0] oCoord_X,
    output logic [CNT_W-1:0] oCoord_Y,
    output logic [7:0]       oR,
    output logic [7:0]       oG,
    output logic [7:0]       oB,
    output logic             oFrame_start,
    output logic             oLocked,
    output logic             oH_err,
    output logic             oV_err
);

    localparam logic [CNT_W-1:0] H_START  = CNT_W'(H_SYNC_CYC + H_BACK);
    localparam logic [CNT_W-1:0] H_STOP   = CNT_W'(H_SYNC_CYC + H_BACK + H_ACT);
    localparam logic [CNT_W-1:0] V_START  = CNT_W'(V_SYNC_CYC + V_BACK);
    localparam logic [CNT_W-1:0] V_STOP   = CNT_W'(V_SYNC_CYC + V_BACK + V_ACT);
    localparam logic [CNT_W-1:0] H_LEN    = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic h_fall, v_fall, h_rise, v_rise;
    logic unused_rise;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] hpos, vpos;
    logic             h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic             h_err_q, h_err_d, v_err_q, v_err_d;
    logic             h_err_ev, v_err_ev, in_win;
    lock_state_e      state_q, state_d;

    logic             valid_q, valid_d, fs_q, fs_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;

    sync_edge_detect u_h_edge (
        .clk    (Clock),
        .rst_n  (Resetn),
        .en_i   (Enable),
        .sync_i (iVGA_H_SYNC),
        .fall_o (h_fall),
        .rise_o (h_rise)
    );

    sync_edge_detect u_v_edge (
        .clk    (Clock),
        .rst_n  (Resetn),
        .en_i   (Enable),
        .sync_i (iVGA_V_SYNC),
        .fall_o (v_fall),
        .rise_o (v_rise)
    );

    assign unused_rise = h_rise ^ v_rise;

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path infers a latch.
        hpos     = h_cnt_q;
        vpos     = v_cnt_q;
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        h_seen_d = h_seen_q;
        v_seen_d = v_seen_q;
        h_err_ev = 1'b0;
        v_err_ev = 1'b0;
        h_err_d  = h_err_q;
        v_err_d  = v_err_q;
        state_d  = state_q;
        in_win   = 1'b0;
        valid_d  = valid_q;
        fs_d     = fs_q;
        x_d      = x_q;
        y_d      = y_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;

        if (Enable) begin
            hpos = h_fall ? '0 : h_cnt_q;
            if (v_fall)      vpos = '0;
            else if (h_fall) vpos = sat_inc(v_cnt_q);
            else             vpos = v_cnt_q;

            h_cnt_d  = sat_inc(hpos);
            v_cnt_d  = vpos;
            h_seen_d = h_seen_q | h_fall;
            v_seen_d = v_seen_q | v_fall;

            // The first edge after reset only establishes phase; later edges are checked.
            h_err_ev = (h_fall && h_seen_q && (h_cnt_q != H_LEN)) || (hpos == CNT_MAX);
            v_err_ev = (v_fall && !h_fall) ||
                       (v_fall && v_seen_q && (v_cnt_q != V_LAST)) ||
                       (vpos == CNT_MAX);

            h_err_d = h_err_ev ? 1'b1 : (iClear_err ? 1'b0 : h_err_q);
            v_err_d = v_err_ev ? 1'b1 : (iClear_err ? 1'b0 : v_err_q);

            if (h_err_ev || v_err_ev) begin
                state_d = S_IDLE;
            end else if (v_fall && h_fall) begin
                case (state_q)
                    S_IDLE:    state_d = S_ACQUIRE;
                    S_ACQUIRE: state_d = S_LOCKED;
                    default:   state_d = state_q;
                endcase
            end

            in_win  = (hpos >= H_START) && (hpos < H_STOP) &&
                      (vpos >= V_START) && (vpos < V_STOP);
            valid_d = (state_d == S_LOCKED) && in_win;
            x_d     = valid_d ? hpos - H_START : '0;
            y_d     = valid_d ? vpos - V_START : '0;
            r_d     = valid_d ? iVGA_R : 8'd0;
            g_d     = valid_d ? iVGA_G : 8'd0;
            b_d     = valid_d ? iVGA_B : 8'd0;
            fs_d    = valid_d && (x_d == '0) && (y_d == '0);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            h_seen_q <= 1'b0;
            v_seen_q <= 1'b0;
            h_err_q  <= 1'b0;
            v_err_q  <= 1'b0;
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            r_q      <= 8'd0;
            g_q      <= 8'd0;
            b_q      <= 8'd0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            h_seen_q <= h_seen_d;
            v_seen_q <= v_seen_d;
            h_err_q  <= h_err_d;
            v_err_q  <= v_err_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            x_q      <= x_d;
            y_q      <= y_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    assign oPixel_valid = valid_q;
    assign oCoord_X     = x_q;
    assign oCoord_Y     = y_q;
    assign oR           = r_q;
    assign oG           = g_q;
    assign oB           = b_q;
    assign oFrame_start = fs_q;
    assign oLocked      = (state_q == S_LOCKED);
    assign oH_err       = h_err_q;
    assign oV_err       = v_err_q;

endmodule
